mips_trace_buffer: RTL

Synthesizable on-chip trace recorder for the pipelined MIPS core, replacing file-based logging of the per-cycle probe set (ALU result, fetched instruction, PC, memory read data) with a parametrised capture buffer. It samples CH probe channels of W bits on each CPU clock enable into a circular buffer. It captures pre-trigger history, fires on a masked compare, records a fixed post-trigger window, and then halts the CPU. The stored entries are streamed out oldest-first over a valid/ready port. The block sits beside the CPU top, fed by the same enable that advances the pipeline.

---
 rtl/mips_trace_buffer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/mips_trace_buffer.sv
// mips_trace_buffer
// On-chip trace recorder for the pipelined MIPS core. On every CPU clock step
// (sample_en) it captures CH probe channels of W bits into a DEPTH-entry
// circular buffer. Capture keeps pre-trigger history, fires on a masked
// compare of channel TRIG_CH, records POST further samples and then requests
// a CPU halt. The stored entries are streamed out oldest-first over a
// valid/ready port.
//
// Optional feature macro: TRACE_TIMESTAMP_EN. When it is defined, every entry
// also carries a TSW-bit cycle timestamp in its top bits (DW = CH*W + TSW).
//
// Ports
//   clk, reset              : rising-edge clock, asynchronous active-high reset
//   sample_en, probe        : sample strobe and packed probe channels
//   trig_mask, trig_value   : masked trigger compare on channel TRIG_CH
//   arm, abort, rd_start    : capture start, return to idle, readout start
//   dout, dout_valid,
//   dout_ready, dout_last   : readout stream, oldest entry first
//   halt, busy, done, count : CPU freeze request, status, stored entry count
module mips_trace_buffer #(
    parameter int CH      = 4,
    parameter int W       = 32,
    parameter int DEPTH   = 16,
    parameter int POST    = 8,
    parameter int TRIG_CH = 0,
    parameter int TSW     = 16,
    localparam int AW     = $clog2(DEPTH),
`ifdef TRACE_TIMESTAMP_EN
    localparam int DW     = CH*W + TSW
`else
    localparam int DW     = CH*W
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sample_en,
    input  logic [CH*W-1:0] probe,
    input  logic [W-1:0]    trig_mask,
    input  logic [W-1:0]    trig_value,
    input  logic            arm,
    input  logic            abort,
    input  logic            rd_start,
    output logic [DW-1:0]   dout,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic            dout_last,
    output logic            halt,
    output logic            busy,
    output logic            done,
    output logic [AW:0]     count
);

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] POST_C  = AW'(POST);
    localparam logic [AW:0]   ONE_C   = (AW+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_POST    = 3'd2,
        S_DONE    = 3'd3,
        S_READOUT = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [DW-1:0]   mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW-1:0]   post_left_r;
    logic [AW:0]     count_r;
    logic [AW:0]     rd_left_r;
    logic            hit_s;
    logic            capturing_s;
    logic            wr_en_s;
    logic [DW-1:0]   entry_s;

    assign hit_s       = ((probe[TRIG_CH*W +: W] & trig_mask) == (trig_value & trig_mask));
    assign capturing_s = (state_r == S_ARMED) || (state_r == S_POST);
    assign wr_en_s     = sample_en && capturing_s && !abort;

`ifdef TRACE_TIMESTAMP_EN
    logic [TSW-1:0] ts_r;

    // Cycle timestamp: cleared on an accepted arm, free-running while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_r <= '0;
        end else if (abort) begin
            ts_r <= ts_r;
        end else if ((state_r == S_IDLE) && arm) begin
            ts_r <= '0;
        end else if (capturing_s) begin
            ts_r <= ts_r + TSW'(1);
        end
    end

    assign entry_s = {ts_r, probe};
`else
    assign entry_s = probe;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; abort overrides every other cause.
    always_comb begin
        state_nxt_s = state_r;
        if (abort) begin
            state_nxt_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (arm) state_nxt_s = S_ARMED;
                    else     state_nxt_s = S_IDLE;
                end
                S_ARMED: begin
                    if (sample_en && hit_s) state_nxt_s = (POST == 0) ? S_DONE : S_POST;
                    else                    state_nxt_s = S_ARMED;
                end
                S_POST: begin
                    if (sample_en && (post_left_r == AW'(1))) state_nxt_s = S_DONE;
                    else                                      state_nxt_s = S_POST;
                end
                S_DONE: begin
                    if (rd_start) state_nxt_s = S_READOUT;
                    else          state_nxt_s = S_DONE;
                end
                S_READOUT: begin
                    if (dout_ready && (rd_left_r == ONE_C)) state_nxt_s = S_IDLE;
                    else                                    state_nxt_s = S_READOUT;
                end
                default: state_nxt_s = S_IDLE;
            endcase
        end
    end

    // Pointers and counters for capture and readout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            post_left_r <= '0;
            count_r     <= '0;
            rd_left_r   <= '0;
        end else if (abort) begin
            count_r     <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (arm) begin
                        wr_ptr_r <= '0;
                        count_r  <= '0;
                    end
                end
                S_ARMED, S_POST: begin
                    if (sample_en) begin
                        wr_ptr_r <= wr_ptr_r + AW'(1);
                        count_r  <= (count_r == DEPTH_C) ? count_r : count_r + ONE_C;
                        if (state_r == S_POST) begin
                            post_left_r <= post_left_r - AW'(1);
                        end else if (hit_s) begin
                            post_left_r <= POST_C;
                        end
                    end
                end
                S_DONE: begin
                    if (rd_start) begin
                        // count == DEPTH has zero low bits, so rd_ptr lands on wr_ptr,
                        // which is exactly the oldest entry of a full buffer.
                        rd_ptr_r  <= wr_ptr_r - count_r[AW-1:0];
                        rd_left_r <= count_r;
                    end
                end
                S_READOUT: begin
                    if (dout_ready) begin
                        rd_ptr_r  <= rd_ptr_r + AW'(1);
                        rd_left_r <= rd_left_r - ONE_C;
                        if (rd_left_r == ONE_C) count_r <= '0;
                    end
                end
                default: begin
                    count_r <= '0;
                end
            endcase
        end
    end

    // Trace storage; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= entry_s;
        end
    end

    assign busy       = capturing_s;
    assign done       = (state_r == S_DONE);
    assign halt       = (state_r == S_DONE) || (state_r == S_READOUT);
    assign dout_valid = (state_r == S_READOUT);
    assign dout_last  = dout_valid && (rd_left_r == ONE_C);
    assign dout       = dout_valid ? mem_r[rd_ptr_r] : '0;
    assign count      = count_r;

endmodule
